// File: rtl/fpa_controller.sv
// Sequencing FSM for a floating-point add datapath: load, add, normalize, done/exception.
// Optional macro FPA_NORM_TIMEOUT_EN bounds normalization to NORM_MAX_ITER shifts.
module fpa_controller #(
  parameter int NORM_MAX_ITER = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       add_except,
  input  logic       norm_except,
  input  logic [4:0] mant,
  output logic       load_en,
  output logic       add_en,
  output logic       norm_en,
  output logic       done_en,
  output logic       shift_right,
  output logic       shift_left,
  output logic       norm_load,
  output logic       busy,
  output logic       done,
  output logic       except_flag,
  output logic       timeout,
  output logic [3:0] dbg_state_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_ADD, S_ADD_CHK, S_NORM_LD, S_NORM_CHK, S_NORM_SH, S_DONE, S_EXC
  } state_t;

  state_t state_q, state_d;
  logic   dir_right_q, dir_right_d;
  logic   timeout_d;
  logic   timeout_hit;

`ifdef FPA_NORM_TIMEOUT_EN
  logic [2:0] count_q;
  assign timeout_hit = (count_q == 3'(NORM_MAX_ITER));
`else
  // Normalization is unbounded; the iteration limit has no effect in this build.
  assign timeout_hit = (NORM_MAX_ITER < 0);
`endif

  always_comb begin
    state_d     = state_q;
    dir_right_d = dir_right_q;
    timeout_d   = 1'b0;
    case (state_q)
      S_IDLE:     if (start) state_d = S_LOAD;
      S_LOAD:     state_d = S_ADD;
      S_ADD:      state_d = S_ADD_CHK;
      S_ADD_CHK:  state_d = add_except ? S_EXC : S_NORM_LD;
      S_NORM_LD:  state_d = S_NORM_CHK;
      S_NORM_CHK: begin
        if (norm_except)                state_d = S_EXC;
        else if (mant == 5'd0)          state_d = S_DONE;
        else if (mant[4:3] == 2'b01)    state_d = S_DONE;
        else if (timeout_hit) begin
          state_d   = S_EXC;
          timeout_d = 1'b1;
        end else begin
          state_d     = S_NORM_SH;
          dir_right_d = mant[4];
        end
      end
      S_NORM_SH:  state_d = S_NORM_CHK;
      S_DONE:     state_d = S_IDLE;
      S_EXC:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= S_IDLE;
      dir_right_q <= 1'b0;
      load_en     <= 1'b0;
      add_en      <= 1'b0;
      norm_en     <= 1'b0;
      done_en     <= 1'b0;
      shift_right <= 1'b0;
      shift_left  <= 1'b0;
      norm_load   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      except_flag <= 1'b0;
      timeout     <= 1'b0;
`ifdef FPA_NORM_TIMEOUT_EN
      count_q     <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      dir_right_q <= dir_right_d;
      load_en     <= (state_d == S_LOAD);
      add_en      <= (state_d == S_ADD);
      norm_en     <= (state_d == S_NORM_LD) || (state_d == S_NORM_SH);
      done_en     <= (state_d == S_DONE);
      shift_right <= (state_d == S_NORM_SH) && dir_right_d;
      shift_left  <= (state_d == S_NORM_SH) && !dir_right_d;
      norm_load   <= (state_d == S_NORM_LD);
      busy        <= (state_d != S_IDLE);
      done        <= (state_d == S_DONE);
      except_flag <= (state_d == S_EXC);
      timeout     <= timeout_d;
`ifdef FPA_NORM_TIMEOUT_EN
      if (state_q == S_NORM_LD)      count_q <= 3'd0;
      else if (state_q == S_NORM_SH) count_q <= count_q + 3'd1;
`endif
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fpa_controller.sv
// Directed bench for fpa_controller: each step checks the full output vector against a constant.
module tb_fpa_controller;

  logic       clk = 1'b0;
  logic       clr;
  logic       start, add_except, norm_except;
  logic [4:0] mant;
  logic       load_en, add_en, norm_en, done_en, shift_right, shift_left, norm_load;
  logic       busy, done, except_flag, timeout;
  logic [3:0] dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // {load,add,norm,done_en,sr,sl,norm_load,busy,done,exc,timeout}
  localparam logic [10:0] O_IDLE = 11'h000;
  localparam logic [10:0] O_LOAD = 11'h408;
  localparam logic [10:0] O_ADD  = 11'h208;
  localparam logic [10:0] O_CHK  = 11'h008;
  localparam logic [10:0] O_NLD  = 11'h118;
  localparam logic [10:0] O_SHR  = 11'h148;
  localparam logic [10:0] O_SHL  = 11'h128;
  localparam logic [10:0] O_DONE = 11'h08C;
  localparam logic [10:0] O_EXC  = 11'h00A;
  localparam logic [10:0] O_TO   = 11'h00B;

  logic [10:0] outs;
  assign outs = {load_en, add_en, norm_en, done_en, shift_right, shift_left,
                 norm_load, busy, done, except_flag, timeout};

  fpa_controller dut (
    .clk(clk), .clr(clr), .start(start), .add_except(add_except),
    .norm_except(norm_except), .mant(mant),
    .load_en(load_en), .add_en(add_en), .norm_en(norm_en), .done_en(done_en),
    .shift_right(shift_right), .shift_left(shift_left), .norm_load(norm_load),
    .busy(busy), .done(done), .except_flag(except_flag), .timeout(timeout),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [10:0] exp);
    total_cnt++;
    assert (outs === exp) pass_cnt++;
    else $error("FAIL %s outs=%03h expected=%03h", tag, outs, exp);
  endtask

  // Start pulse sampled on the next edge, then walk to the first NORM_CHK.
  task automatic run_to_chk(input string tag);
    start = 1'b1;
    tick(); start = 1'b0;
    chk({tag, "_load"}, O_LOAD);
    tick(); tick(); tick(); tick();
    chk({tag, "_chk0"}, O_CHK);
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; add_except = 1'b0; norm_except = 1'b0; mant = 5'b01010;
    #2;
    chk("reset_async", O_IDLE);
    tick(); tick();
    chk("reset_held", O_IDLE);
    clr = 1'b1;

    // Already normalized: done in cycle 6
    start = 1'b1;
    tick(); start = 1'b0;
    chk("n_load", O_LOAD);
    tick(); chk("n_add", O_ADD);
    tick(); chk("n_addchk", O_CHK);
    tick(); chk("n_normld", O_NLD);
    tick(); chk("n_normchk", O_CHK);
    tick(); chk("n_done", O_DONE);
    tick(); chk("n_idle", O_IDLE);
    tick(); chk("n_stay_idle", O_IDLE);

    // Carry set: one right shift, done in cycle 8
    mant = 5'b10110;
    run_to_chk("r");
    tick(); chk("r_shr", O_SHR); mant = 5'b01011;
    tick(); chk("r_chk1", O_CHK);
    tick(); chk("r_done", O_DONE);
    tick(); chk("r_idle", O_IDLE);

    // Add-stage exception
    start = 1'b1;
    tick(); start = 1'b0;
    chk("a_load", O_LOAD);
    tick(); chk("a_add", O_ADD); add_except = 1'b1;
    tick(); chk("a_addchk", O_CHK);
    tick(); chk("a_exc", O_EXC); add_except = 1'b0;
    tick(); chk("a_idle", O_IDLE);

    // Left shifts until the hidden bit lands
    mant = 5'b00001;
    run_to_chk("l");
    tick(); chk("l_shl1", O_SHL); mant = 5'b00010;
    tick(); chk("l_chk1", O_CHK);
    tick(); chk("l_shl2", O_SHL); mant = 5'b00100;
    tick(); chk("l_chk2", O_CHK);
    tick(); chk("l_shl3", O_SHL); mant = 5'b01000;
    tick(); chk("l_chk3", O_CHK);
    tick(); chk("l_done", O_DONE);
    tick(); chk("l_idle", O_IDLE);

    // Zero mantissa finishes without shifting
    mant = 5'b00000;
    run_to_chk("z");
    tick(); chk("z_done", O_DONE);
    tick(); chk("z_idle", O_IDLE);

    // Exponent saturation wins over a normalized mantissa
    mant = 5'b01000; norm_except = 1'b1;
    run_to_chk("e");
    tick(); chk("e_exc", O_EXC); norm_except = 1'b0;
    tick(); chk("e_idle", O_IDLE);

`ifdef FPA_NORM_TIMEOUT_EN
    mant = 5'b00001;
    run_to_chk("t");
    for (int i = 0; i < 4; i++) begin
      tick(); chk("t_shl", O_SHL);
      tick(); chk("t_chk", O_CHK);
    end
    tick(); chk("t_timeout", O_TO);
    tick(); chk("t_idle", O_IDLE);
`endif

    // Reset in NORM_SH abandons the operation immediately
    mant = 5'b00100;
    run_to_chk("c");
    tick(); chk("c_shl", O_SHL);
    clr = 1'b0;
    #1 chk("c_async_clr", O_IDLE);
    tick(); chk("c_clr_held", O_IDLE);

    // Release with start already high: honoured on the next edge, one operation only
    clr = 1'b1; start = 1'b1; mant = 5'b01010;
    tick(); chk("h_load", O_LOAD);
    tick(); chk("h_add", O_ADD);
    tick(); chk("h_addchk", O_CHK);
    tick(); chk("h_normld", O_NLD);
    tick(); chk("h_normchk", O_CHK);
    tick(); chk("h_done", O_DONE);
    tick(); chk("h_idle", O_IDLE); start = 1'b0;
    tick(); chk("h_idle2", O_IDLE);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fpa_controller.md
FPA_CONTROLLER -- requirements
Module: fpa_controller

Interface
REQ-001 The block SHALL have parameter NORM_MAX_ITER, default 4, the maximum number of normalization shifts allowed per operation (only used when FPA_NORM_TIMEOUT_EN is defined).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-004 The block SHALL have port clr  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  in  1  request to begin one add.
REQ-006 The block SHALL have port add_except  in  1  datapath add-stage exception (zero/overflow/underflow).
REQ-007 The block SHALL have port norm_except  in  1  datapath exponent-saturation exception.
REQ-008 The block SHALL have port mant  in  5  current normalization-register mantissa {carry, hidden, m[2:0]}.
REQ-009 The block SHALL have ports load_en, add_en, norm_en, done_en  out  1 each  datapath register enables.
REQ-010 The block SHALL have ports shift_right, shift_left, norm_load  out  1 each  datapath shift and mux selects.
REQ-011 The block SHALL have ports busy, done, except_flag, timeout  out  1 each  status outputs.

Function
REQ-012 The FSM SHALL have the states IDLE, LOAD, ADD, ADD_CHK, NORM_LD, NORM_CHK, NORM_SH, DONE and EXC; all outputs SHALL be Moore, decoded from the state register only.
REQ-013 In IDLE with start=1 the FSM SHALL go to LOAD; in IDLE with start=0 it SHALL stay in IDLE; start SHALL be ignored in every other state.
REQ-014 LOAD SHALL assert load_en and then go to ADD; ADD SHALL assert add_en and then go to ADD_CHK.
REQ-015 ADD_CHK SHALL assert no enables; add_except=1 SHALL go to EXC, otherwise the FSM SHALL go to NORM_LD.
REQ-016 NORM_LD SHALL assert norm_en and norm_load, then go to NORM_CHK.
REQ-017 NORM_CHK SHALL assert no enables and evaluate its inputs in this priority order:
  - norm_except=1 -> EXC
  - mant==0 -> DONE
  - mant[4]=1 -> NORM_SH, right shift
  - mant[4:3]==00 -> NORM_SH, left shift
  - mant[4:3]==01 -> DONE
REQ-018 NORM_SH SHALL assert norm_en together with exactly one of shift_right/shift_left, as latched in NORM_CHK, then return to NORM_CHK; shift_right and shift_left SHALL never be asserted together.
REQ-019 DONE SHALL assert done_en and done for exactly one cycle, then return to IDLE.
REQ-020 EXC SHALL assert except_flag for exactly one cycle, never assert done_en, then return to IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 Latency SHALL be 6 cycles from the start-sampling edge to done for an already-normalized result, plus 2 cycles per shift.

Reset
REQ-023 With clr=0 the FSM SHALL enter IDLE immediately, regardless of clk, and every output SHALL be 0.
REQ-024 Asserting clr mid-operation SHALL abandon the operation with no done and no except_flag pulse.
REQ-025 After clr is released, the first start SHALL be honoured on the next rising edge.

Configuration
REQ-026 With macro FPA_NORM_TIMEOUT_EN defined, a 3-bit shift counter SHALL clear in NORM_LD and increment in NORM_SH.
REQ-027 With FPA_NORM_TIMEOUT_EN defined, NORM_CHK with count==NORM_MAX_ITER and a non-normalized, non-zero mant SHALL go to EXC, asserting timeout together with except_flag for that one cycle.
REQ-028 Without FPA_NORM_TIMEOUT_EN, the counter SHALL be absent, timeout SHALL be tied to 0, and normalization SHALL end only via REQ-017.

Verification
REQ-029 clr=0 then 1, start pulsed at edge 0, add_except=0, mant=01010 -> done=1 at cycle 6, done_en=1 at cycle 6, no shift asserted.
REQ-030 Start, mant=10110 in the first NORM_CHK, then 01011 -> one shift_right pulse, done at cycle 8.
REQ-031 Start, add_except=1 in ADD_CHK -> except_flag at cycle 4, norm_en never asserted, FSM back in IDLE at cycle 5.
REQ-032 Start, mant held at 00001 with the macro defined -> 4 shift_left pulses, then timeout=1 and except_flag=1; without the macro -> left shifts continue until mant=01000, then done.
REQ-033 clr=0 during NORM_SH -> all outputs 0 immediately; start held high through busy -> exactly one operation.
REQ-034 norm_except=1 in NORM_CHK with mant=01000 -> EXC taken, done never asserted.
